mips_store_monitor: RTL and testbench



---
 rtl/mips_store_monitor.sv | 135 +++++++++++++
 tb/tb_mips_store_monitor.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_store_monitor.sv
// Self-check stage for the single-cycle MIPS core: watches the data-memory write
// bus, logs stores in a circular buffer and decides PASS, FAIL or TIMEOUT.
module mips_store_monitor #(
    parameter logic [31:0] PASS_ADDR      = 32'd84,
    parameter logic [31:0] PASS_DATA      = 32'd7,
    parameter logic [31:0] ALLOW_ADDR     = 32'd80,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned LOG_DEPTH      = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         we,
    input  logic [31:0]                  dataadr,
    input  logic [31:0]                  writedata,
    input  logic [$clog2(LOG_DEPTH)-1:0] log_rd_idx,
    output logic [31:0]                  log_rd_addr,
    output logic [31:0]                  log_rd_data,
    output logic [$clog2(LOG_DEPTH):0]   log_fill,
    output logic [15:0]                  store_count,
    output logic [31:0]                  cycle_count,
    output logic                         done,
    output logic                         pass,
    output logic                         fail,
    output logic                         timeout,
    output logic [31:0]                  fail_addr,
    output logic [31:0]                  fail_data
);

    localparam int IW = $clog2(LOG_DEPTH);
    localparam logic [IW:0] FILL_MAX    = (IW+1)'(LOG_DEPTH);
    localparam logic [31:0] TIMEOUT_VAL = 32'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [IW:0]    fill_q, fill_d;
    logic [15:0]    store_cnt_q, store_cnt_d;
    logic [31:0]    cyc_q, cyc_d;
    logic [31:0]    fail_addr_q, fail_addr_d;
    logic [31:0]    fail_data_q, fail_data_d;
    logic           log_we;

    logic [31:0]    log_addr_q [LOG_DEPTH];
    logic [31:0]    log_data_q [LOG_DEPTH];

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        store_cnt_d = store_cnt_q;
        cyc_d       = cyc_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        log_we      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The arming edge only changes state; the bus is not sampled.
                if (enable) state_d = S_RUN;
            end
            S_RUN: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else begin
                    if (we) begin
                        log_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + IW'(1);
                        if (fill_q != FILL_MAX) fill_d = fill_q + (IW+1)'(1);
                        if (store_cnt_q != 16'hFFFF) store_cnt_d = store_cnt_q + 16'd1;
                        if (dataadr == PASS_ADDR && writedata == PASS_DATA) begin
                            state_d = S_PASS;
                        end else if (dataadr != ALLOW_ADDR) begin
                            state_d     = S_FAIL;
                            fail_addr_d = dataadr;
                            fail_data_d = writedata;
                        end
                    end
                    cyc_d = cyc_q + 32'd1;
                    // A store verdict on this edge takes precedence over timeout.
                    if (cyc_d == TIMEOUT_VAL && state_d == S_RUN) state_d = S_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            store_cnt_q <= '0;
            cyc_q       <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            for (int i = 0; i < LOG_DEPTH; i++) begin
                log_addr_q[i] <= '0;
                log_data_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            store_cnt_q <= store_cnt_d;
            cyc_q       <= cyc_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            if (log_we) begin
                log_addr_q[wr_ptr_q] <= dataadr;
                log_data_q[wr_ptr_q] <= writedata;
            end
        end
    end

    assign log_rd_addr = log_addr_q[log_rd_idx];
    assign log_rd_data = log_data_q[log_rd_idx];
    assign log_fill    = fill_q;
    assign store_count = store_cnt_q;
    assign cycle_count = cyc_q;
    assign pass        = (state_q == S_PASS);
    assign fail        = (state_q == S_FAIL);
    assign timeout     = (state_q == S_TIMEOUT);
    assign done        = pass | fail | timeout;
    assign fail_addr   = fail_addr_q;
    assign fail_data   = fail_data_q;

endmodule

// File: tb/tb_mips_store_monitor.sv
// Scoreboard bench for mips_store_monitor: a reference model predicts each edge,
// predictions are queued at drive time and popped after the edge for comparison.
module tb_mips_store_monitor;

    localparam int TO = 20;
    localparam int LD = 8;

    logic        clk = 1'b0;
    logic        reset, enable, we;
    logic [31:0] dataadr, writedata;
    logic [2:0]  log_rd_idx;
    logic [31:0] log_rd_addr, log_rd_data;
    logic [3:0]  log_fill;
    logic [15:0] store_count;
    logic [31:0] cycle_count, fail_addr, fail_data;
    logic        done, pass, fail, timeout;

    int n_chk = 0;
    int n_fail = 0;

    mips_store_monitor #(.TIMEOUT_CYCLES(TO), .LOG_DEPTH(LD)) dut (
        .clk(clk), .reset(reset), .enable(enable), .we(we),
        .dataadr(dataadr), .writedata(writedata), .log_rd_idx(log_rd_idx),
        .log_rd_addr(log_rd_addr), .log_rd_data(log_rd_data), .log_fill(log_fill),
        .store_count(store_count), .cycle_count(cycle_count), .done(done),
        .pass(pass), .fail(fail), .timeout(timeout),
        .fail_addr(fail_addr), .fail_data(fail_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] cc;
        logic [15:0] sc;
        logic [3:0]  fill;
        logic        d, p, f, t;
        logic [31:0] fa, fd;
    } exp_t;

    exp_t exp_q[$];

    // reference model; states 0 idle, 1 run, 2 pass, 3 fail, 4 timeout
    int          m_st;
    logic [31:0] m_cc, m_fa, m_fd;
    logic [15:0] m_sc;
    int          m_fill, m_ptr;
    logic [31:0] m_la [LD];
    logic [31:0] m_ld [LD];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_cc = 0; m_sc = 0; m_fill = 0; m_ptr = 0; m_fa = 0; m_fd = 0;
        for (int i = 0; i < LD; i++) begin m_la[i] = 0; m_ld[i] = 0; end
    endtask

    task automatic model_step(input logic en, input logic w, input logic [31:0] a, input logic [31:0] d);
        if (m_st == 0) begin
            if (en) m_st = 1;
        end else if (m_st == 1) begin
            if (!en) m_st = 0;
            else begin
                if (w) begin
                    m_la[m_ptr] = a; m_ld[m_ptr] = d;
                    m_ptr = (m_ptr + 1) % LD;
                    if (m_fill < LD) m_fill++;
                    if (m_sc != 16'hFFFF) m_sc++;
                    if (a == 32'd84 && d == 32'd7) m_st = 2;
                    else if (a != 32'd80) begin m_st = 3; m_fa = a; m_fd = d; end
                end
                m_cc++;
                if (m_cc == TO && m_st == 1) m_st = 4;
            end
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".done"}, {31'd0, done}, 0);
        chk({tag, ".pass"}, {31'd0, pass}, 0);
        chk({tag, ".fail"}, {31'd0, fail}, 0);
        chk({tag, ".timeout"}, {31'd0, timeout}, 0);
        chk({tag, ".cycle_count"}, cycle_count, 0);
        chk({tag, ".store_count"}, {16'd0, store_count}, 0);
        chk({tag, ".log_fill"}, {28'd0, log_fill}, 0);
        chk({tag, ".fail_addr"}, fail_addr, 0);
        chk({tag, ".fail_data"}, fail_data, 0);
        chk({tag, ".log_rd_data"}, log_rd_data, 0);
    endtask

    // Drive one cycle of stimulus, queue the prediction, compare after the edge.
    task automatic step(input string tag, input logic en, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
        exp_t e, g;
        enable = en; we = w; dataadr = a; writedata = d;
        model_step(en, w, a, d);
        e.cc = m_cc; e.sc = m_sc; e.fill = 4'(m_fill);
        e.d = (m_st >= 2); e.p = (m_st == 2); e.f = (m_st == 3); e.t = (m_st == 4);
        e.fa = m_fa; e.fd = m_fd;
        exp_q.push_back(e);
        @(posedge clk); #1;
        g = exp_q.pop_front();
        chk({tag, ".done"}, {31'd0, done}, {31'd0, g.d});
        chk({tag, ".pass"}, {31'd0, pass}, {31'd0, g.p});
        chk({tag, ".fail"}, {31'd0, fail}, {31'd0, g.f});
        chk({tag, ".timeout"}, {31'd0, timeout}, {31'd0, g.t});
        chk({tag, ".cycle_count"}, cycle_count, g.cc);
        chk({tag, ".store_count"}, {16'd0, store_count}, {16'd0, g.sc});
        chk({tag, ".log_fill"}, {28'd0, log_fill}, {28'd0, g.fill});
        chk({tag, ".fail_addr"}, fail_addr, g.fa);
        chk({tag, ".fail_data"}, fail_data, g.fd);
        chk({tag, ".log_rd_addr"}, log_rd_addr, m_la[log_rd_idx]);
        chk({tag, ".log_rd_data"}, log_rd_data, m_ld[log_rd_idx]);
    endtask

    task automatic do_reset(input string tag);
        #2; reset = 1'b0; enable = 1'b0; we = 1'b0;
        #1;
        model_reset();
        check_zero(tag);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test1(input string tag);
        step({tag, ".arm"}, 1, 1, 32'd88, 32'd3);   // store on arming edge is ignored
        step({tag, ".s1"}, 1, 1, 32'd80, 32'd5);
        step({tag, ".s2"}, 1, 1, 32'd80, 32'd9);
        step({tag, ".s3"}, 1, 1, 32'd84, 32'd7);
        chk({tag, ".pass_set"}, {31'd0, pass}, 1);
        chk({tag, ".sc3"}, {16'd0, store_count}, 3);
    endtask

    initial begin
        reset = 1'b1; enable = 0; we = 0; dataadr = 0; writedata = 0; log_rd_idx = 0;
        model_reset();
        @(posedge clk); #1;
        do_reset("rst0");

        test1("t1");
        step("t1.sticky", 1, 1, 32'd88, 32'd1);
        step("t1.sticky2", 0, 1, 32'd84, 32'd7);

        do_reset("rst2");
        step("t2.arm", 1, 0, 0, 0);
        step("t2.s1", 1, 1, 32'd80, 32'd1);
        step("t2.s2", 1, 1, 32'd88, 32'd3);
        step("t2.s3", 1, 1, 32'd84, 32'd7);
        chk("t2.fail_addr88", fail_addr, 32'd88);
        chk("t2.sc2", {16'd0, store_count}, 2);

        do_reset("rst3");
        step("t3.arm", 1, 0, 0, 0);
        step("t3.s1", 1, 1, 32'd84, 32'd6);
        chk("t3.fail_data6", fail_data, 32'd6);

        do_reset("rst4a");
        step("t4a.arm", 1, 0, 0, 0);
        for (int k = 1; k <= TO; k++) step($sformatf("t4a.c%0d", k), 1, 0, 0, 0);
        chk("t4a.timeout_at20", {31'd0, timeout}, 1);
        chk("t4a.cc20", cycle_count, 32'd20);

        do_reset("rst4b");
        step("t4b.arm", 1, 0, 0, 0);
        for (int k = 1; k < TO; k++) step($sformatf("t4b.c%0d", k), 1, 0, 0, 0);
        step("t4b.last", 1, 1, 32'd84, 32'd7);
        chk("t4b.pass_beats_to", {30'd0, pass, timeout}, 32'd2);

        do_reset("rst5");
        step("t5.arm", 1, 0, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            log_rd_idx = 3'(k - 1);
            step($sformatf("t5.s%0d", k), 1, 1, 32'd80, 32'(k));
        end
        chk("t5.fill8", {28'd0, log_fill}, 8);
        log_rd_idx = 3'd0; #1; chk("t5.slot0", log_rd_data, 32'd9);
        log_rd_idx = 3'd1; #1; chk("t5.slot1", log_rd_data, 32'd10);
        log_rd_idx = 3'd2; #1; chk("t5.slot2", log_rd_data, 32'd3);
        log_rd_idx = 3'd0;

        do_reset("rst6");
        step("t6.arm", 1, 0, 0, 0);
        step("t6.s1", 1, 1, 32'd80, 32'd1);
        step("t6.s2", 1, 1, 32'd80, 32'd2);
        step("t6.s3", 1, 1, 32'd80, 32'd3);
        do_reset("t6.async");
        test1("t6.rerun");

        do_reset("rst7");
        step("t7.arm", 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) step($sformatf("t7.run%0d", k), 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) step($sformatf("t7.pause%0d", k), 0, 1, 32'd88, 32'd1);
        chk("t7.cc_hold", cycle_count, 32'd3);
        step("t7.rearm", 1, 0, 0, 0);
        step("t7.run3", 1, 0, 0, 0);
        chk("t7.cc_resume", cycle_count, 32'd4);

        if (exp_q.size() != 0) chk("scoreboard.empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
